magia_l2_bank_arbiter: RTL and testbench
========================================

# magia_l2_bank_arbiter

Shares one L2 memory bank port between `NumReq` request/grant requesters (NI-side AXI-to-mem converters or local masters) in the MAGIA mesh L2 subsystem. Arbitration is round-robin, and the arbiter locks its choice while the bank stalls. Each accepted request's requester index is stored in an in-order tracking FIFO, so the bank's in-order responses route back to the correct requester. Outstanding transactions are bounded by `MaxOutstanding`.

## Interface
- `NumReq`, 4: number of requesters, ≥2.
- `AddrWidth`, 32: address width.
- `DataWidth`, 32: data width; `BeWidth = DataWidth/8`.
- `MaxOutstanding`, 4: tracking FIFO depth, ≥1.

Ports:
- `clk_i`  in  1  clock. One clock domain; all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  NumReq  per-requester request.
- `gnt_o`  out  NumReq  per-requester grant.
- `addr_i`  in  NumReq×AddrWidth  request address.
- `we_i`  in  NumReq  write enable.
- `be_i`  in  NumReq×BeWidth  byte enables.
- `wdata_i`  in  NumReq×DataWidth  write data.
- `rvalid_o`  out  NumReq  response valid, one per accepted request.
- `rdata_o`  out  NumReq×DataWidth  response data, broadcast to all requesters.
- `err_o`  out  NumReq  response error, qualified by `rvalid_o`.
- `mem_req_o`  out  1  bank request.
- `mem_gnt_i`  in  1  bank grant.
- `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wdata_o`  out  widths as above  selected payload.
- `mem_rvalid_i`  in  1  bank response; responses return in acceptance order.
- `mem_rdata_i`  in  DataWidth  bank read data.
- `mem_err_i`  in  1  bank error.
- `outstanding_o`  out  $clog2(MaxOutstanding+1)  FIFO occupancy.
- `proto_err_o`  out  1  sticky flag: response arrived with no transaction outstanding.

## Operation
- **Protocol rules.**
  - A requester holds `req_i` and its payload stable until `gnt_o` is high.
  - The arbiter holds `mem_req_o` and the mem payload stable until `mem_gnt_i` is high.
- **State.**
  - `rr_ptr` (reset 0).
  - `locked` (reset 0) and `lock_idx` (reset 0).
  - Tracking FIFO of requester indices: `rd_ptr`, `wr_ptr`, `count`, all reset 0.
  - `proto_err` (reset 0).
- **Selection.**
  - If `locked`, `sel = lock_idx`.
  - Otherwise `sel` is the first `i` with `req_i[i]`, searching from `rr_ptr` upward with wrap at `NumReq`.
- **Bank request.** `mem_req_o = (locked | any req_i) & (count < MaxOutstanding)`. The mem payload is muxed from `sel`.
- **Handshake.**
  - `gnt_o[sel] = mem_req_o & mem_gnt_i`; all other grants are 0.
  - On handshake: push `sel` into the FIFO, set `rr_ptr = (sel+1) mod NumReq`, clear `locked`.
- **Lock.** If `mem_req_o & !mem_gnt_i & !locked`, set `locked = 1` and `lock_idx = sel`. This freezes the choice while the bank stalls.
- **FIFO full.**
  - `count == MaxOutstanding` forces `mem_req_o = 0`; requesters wait.
  - A pop in the same cycle does NOT free the slot for a push in that cycle. This keeps `mem_rvalid_i` out of the path to `mem_req_o`.
- **Response routing.**
  - On `mem_rvalid_i` with `count > 0`: pop the head index `h`; drive `rvalid_o[h] = 1` and `err_o[h] = mem_err_i`.
  - `rdata_o` is `mem_rdata_i` broadcast to all requesters.
- **Spurious response.** On `mem_rvalid_i` with `count == 0`: no `rvalid_o` is raised, and `proto_err` is set and held until reset.
- **Simultaneous push and pop.** `count` is unchanged; both pointers advance, each wrapping at `MaxOutstanding`.
- **Occupancy.** `outstanding_o = count`.

## Timing
- **Combinational paths.**
  - `gnt_o` follows `mem_gnt_i` combinationally, with zero added latency.
  - `rvalid_o`, `rdata_o` and `err_o` follow `mem_rvalid_i` combinationally, with zero added latency.
- **Throughput.** Up to one grant per cycle while `count < MaxOutstanding`.
- **Reset values.** With `rst_ni` low, all outputs are 0: `gnt_o`, `rvalid_o`, `err_o`, `mem_req_o`, `outstanding_o`, `proto_err_o`. All internal state clears asynchronously.
- **Reset mid-operation.** In-flight bank responses that arrive after release hit an empty FIFO and set `proto_err_o`. System reset must cover the bank as well.
- **Fairness.** Under continuous requests from all requesters, each gets exactly one grant in every `NumReq` consecutive grants.

## Test plan
- **Reset.** Hold `rst_ni` low 3 cycles with random inputs -> all outputs 0. After release, the first grant goes to the lowest requesting index (`rr_ptr = 0`).
- **Round-robin.** NumReq=4; all `req_i = 1111`, `mem_gnt_i = 1`, bank responds 2 cycles after each grant -> grants in order 0,1,2,3,0,…. Each requester receives `rvalid_o` with its own `rdata`.
- **Lock under stall.** req1 active; `mem_gnt_i = 0` for 3 cycles while req0 rises -> `mem_addr_o` stays req1's address. `gnt_o[1]` fires when `mem_gnt_i = 1`; req0 is granted next.
- **FIFO full.** MaxOutstanding=4; grant 4 with no responses -> `outstanding_o = 4` and `mem_req_o = 0`.
- **Full-FIFO pop.** From the full state, one `mem_rvalid_i` -> no grant that cycle, grant on the next cycle, `outstanding_o` returns to 4.
- **Simultaneous push/pop and error.** Push and pop in the same cycle -> `outstanding_o` unchanged. `mem_err_i = 1` on req2's response -> `err_o[2] = 1` only.
- **Spurious response.** `mem_rvalid_i` with `outstanding_o = 0` -> no `rvalid_o`. `proto_err_o = 1` and stays 1 until reset.

Source files
------------

// File: rtl/magia_l2_bank_arbiter.sv
// Round-robin arbiter sharing one L2 bank port between NumReq requesters.
// Locks its choice across bank stalls and routes in-order responses back via a tracking FIFO.
module magia_l2_bank_arbiter #(
   parameter  int unsigned NumReq         = 4,
   parameter  int unsigned AddrWidth      = 32,
   parameter  int unsigned DataWidth      = 32,
   parameter  int unsigned MaxOutstanding = 4,
   localparam int unsigned BeWidth        = DataWidth / 8,
   localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumReq-1:0]                    req_i,
   output logic [NumReq-1:0]                    gnt_o,
   input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
   input  logic [NumReq-1:0]                    we_i,
   input  logic [NumReq-1:0][BeWidth-1:0]       be_i,
   input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
   output logic [NumReq-1:0]                    rvalid_o,
   output logic [NumReq-1:0][DataWidth-1:0]     rdata_o,
   output logic [NumReq-1:0]                    err_o,
   output logic                                 mem_req_o,
   input  logic                                 mem_gnt_i,
   output logic [AddrWidth-1:0]                 mem_addr_o,
   output logic                                 mem_we_o,
   output logic [BeWidth-1:0]                   mem_be_o,
   output logic [DataWidth-1:0]                 mem_wdata_o,
   input  logic                                 mem_rvalid_i,
   input  logic [DataWidth-1:0]                 mem_rdata_i,
   input  logic                                 mem_err_i,
   output logic [CntWidth-1:0]                  outstanding_o,
   output logic                                 proto_err_o
);

   localparam int unsigned IdxWidth = $clog2(NumReq);
   localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   logic [IdxWidth-1:0] r_rr_ptr;
   logic [IdxWidth-1:0] r_lock_idx;
   logic                r_locked;
   logic [IdxWidth-1:0] r_fifo [MaxOutstanding];
   logic [PtrWidth-1:0] r_rd_ptr;
   logic [PtrWidth-1:0] r_wr_ptr;
   logic [CntWidth-1:0] r_count;
   logic                r_proto_err;

   logic [IdxWidth-1:0] w_rr_sel;
   logic [IdxWidth-1:0] w_sel;
   logic [IdxWidth-1:0] w_head;
   logic                w_found;
   logic                w_not_full;
   logic                w_mem_req;
   logic                w_push;
   logic                w_pop;
   logic                w_spurious;

   function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
      return (32'(p) == MaxOutstanding - 1) ? '0 : p + PtrWidth'(1);
   endfunction

   // First requester at or after r_rr_ptr, wrapping at NumReq
   always_comb begin
      w_rr_sel = r_rr_ptr;
      w_found  = 1'b0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!w_found && req_i[IdxWidth'((32'(r_rr_ptr) + k) % NumReq)]) begin
            w_found  = 1'b1;
            w_rr_sel = IdxWidth'((32'(r_rr_ptr) + k) % NumReq);
         end
      end
   end

   // Full check uses only the registered count so mem_rvalid_i never reaches mem_req_o
   assign w_sel      = r_locked ? r_lock_idx : w_rr_sel;
   assign w_not_full = (r_count < CntWidth'(MaxOutstanding));
   assign w_mem_req  = rst_ni & (r_locked | (|req_i)) & w_not_full;
   assign w_push     = w_mem_req & mem_gnt_i;
   assign w_pop      = rst_ni & mem_rvalid_i & (r_count != '0);
   assign w_spurious = mem_rvalid_i & (r_count == '0);
   assign w_head     = r_fifo[r_rd_ptr];

   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      err_o    = '0;
      if (w_push) gnt_o[w_sel] = 1'b1;
      if (w_pop) begin
         rvalid_o[w_head] = 1'b1;
         err_o[w_head]    = mem_err_i;
      end
   end

   assign mem_req_o     = w_mem_req;
   assign mem_addr_o    = addr_i[w_sel];
   assign mem_we_o      = we_i[w_sel];
   assign mem_be_o      = be_i[w_sel];
   assign mem_wdata_o   = wdata_i[w_sel];
   assign rdata_o       = {NumReq{mem_rdata_i}};
   assign outstanding_o = r_count;
   assign proto_err_o   = r_proto_err;

   // Round-robin pointer and stall lock
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr   <= '0;
         r_locked   <= 1'b0;
         r_lock_idx <= '0;
      end else if (w_push) begin
         r_rr_ptr <= (32'(w_sel) == NumReq - 1) ? '0 : w_sel + IdxWidth'(1);
         r_locked <= 1'b0;
      end else if (w_mem_req && !r_locked) begin
         r_locked   <= 1'b1;
         r_lock_idx <= w_sel;
      end
   end

   // Tracking FIFO of granted requester indices and sticky protocol error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_proto_err <= 1'b0;
         for (int i = 0; i < int'(MaxOutstanding); i++) r_fifo[i] <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= ptr_next(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntWidth'(1);
            2'b01:   r_count <= r_count - CntWidth'(1);
            default: r_count <= r_count;
         endcase
         if (w_spurious) r_proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_magia_l2_bank_arbiter.sv
// Randomized bench for magia_l2_bank_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_magia_l2_bank_arbiter;
   localparam int N    = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 4;
   localparam int CW   = $clog2(MAXO + 1);

   typedef struct {
      int            idx;
      logic [AW-1:0] addr;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]          req, we;
   logic [N-1:0][AW-1:0]  addr;
   logic [N-1:0][BW-1:0]  be;
   logic [N-1:0][DW-1:0]  wdata;
   logic                  mem_gnt, mem_rvalid, mem_err;
   logic [DW-1:0]         mem_rdata;

   logic [N-1:0]          gnt, rvalid, err;
   logic [N-1:0][DW-1:0]  rdata;
   logic                  mem_req, mem_we;
   logic [AW-1:0]         mem_addr;
   logic [BW-1:0]         mem_be;
   logic [DW-1:0]         mem_wdata;
   logic [CW-1:0]         outstanding;
   logic                  proto_err;

   magia_l2_bank_arbiter #(
      .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
      .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(outstanding), .proto_err_o(proto_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int            m_rr;
   bit            m_locked;
   int            m_lock_idx;
   ent_t          m_q[$];
   bit            m_perr;
   logic [AW-1:0] bank_q[$];
   logic [N-1:0]  last_gnt;

   function automatic logic [DW-1:0] rdf(input logic [AW-1:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_rr = 0; m_locked = 0; m_lock_idx = 0; m_perr = 0;
      m_q.delete(); bank_q.delete(); last_gnt = '0;
   endtask

   task automatic drive_bank(input bit v, input bit e);
      mem_rvalid = v;
      mem_err    = e;
      mem_rdata  = (bank_q.size() > 0) ? rdf(bank_q[0]) : DW'($urandom);
   endtask

   // One clock: compare DUT against model at negedge, advance model, return at posedge+1
   task automatic step();
      int           sel;
      bit           found, exp_req, push, pop;
      logic [N-1:0] eg, erv, eerr;
      @(negedge clk);
      sel = m_rr; found = 0;
      if (m_locked) sel = m_lock_idx;
      else
         for (int k = 0; k < N; k++)
            if (!found && req[(m_rr + k) % N]) begin found = 1; sel = (m_rr + k) % N; end
      exp_req = (m_locked || (|req)) && (m_q.size() < MAXO);
      push    = exp_req && mem_gnt;
      pop     = mem_rvalid && (m_q.size() > 0);
      eg = '0; erv = '0; eerr = '0;
      if (push) eg[sel] = 1'b1;
      if (pop) begin erv[m_q[0].idx] = 1'b1; eerr[m_q[0].idx] = mem_err; end
      chk("mem_req", 128'(mem_req), 128'(exp_req));
      chk("gnt", 128'(gnt), 128'(eg));
      chk("rvalid", 128'(rvalid), 128'(erv));
      chk("err", 128'(err), 128'(eerr));
      chk("outstanding", 128'(outstanding), 128'(m_q.size()));
      chk("proto_err", 128'(proto_err), 128'(m_perr));
      if (exp_req)
         chk("mem_payload", 128'({mem_addr, mem_we, mem_be, mem_wdata}),
             128'({addr[sel], we[sel], be[sel], wdata[sel]}));
      if (mem_rvalid) chk("rdata_bcast", 128'(rdata), 128'({N{mem_rdata}}));
      if (pop) chk("rdata_own", 128'(rdata[m_q[0].idx]), 128'(rdf(m_q[0].addr)));
      // model update
      if (mem_rvalid && m_q.size() == 0) m_perr = 1;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         m_q.push_back('{idx: sel, addr: addr[sel]});
         m_rr = (sel + 1) % N;
         m_locked = 0;
      end else if (exp_req && !m_locked) begin
         m_locked = 1; m_lock_idx = sel;
      end
      // bank behaviour
      if (mem_rvalid && bank_q.size() > 0) void'(bank_q.pop_front());
      if (mem_req && mem_gnt) bank_q.push_back(mem_addr);
      last_gnt = eg;
      @(posedge clk); #1;
   endtask

   task automatic rand_req(input bit allow_new);
      for (int i = 0; i < N; i++) begin
         if (req[i] && last_gnt[i]) req[i] = 1'b0;
         if (!req[i] && allow_new && $urandom_range(0, 99) < 40) begin
            req[i]   = 1'b1;
            addr[i]  = AW'($urandom);
            we[i]    = 1'($urandom);
            be[i]    = BW'($urandom);
            wdata[i] = DW'($urandom);
         end
      end
   endtask

   task automatic clear_inputs();
      req = '0; we = '0; addr = '0; be = '0; wdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         req = N'($urandom); mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
         mem_err = 1'($urandom); mem_rdata = DW'($urandom);
         for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
         #2;
         chk("reset_outputs", 128'({gnt, rvalid, err, mem_req, outstanding, proto_err}), 128'(0));
         @(posedge clk); #1;
      end
      clear_inputs();
      model_clear();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_clear();
      @(posedge clk); #1;

      // Reset, then first grant goes to lowest requesting index
      do_reset();
      chk("post_reset_proto_err", 128'(proto_err), 128'(0));
      req = 4'b1010; addr[1] = 32'h0000_1000; addr[3] = 32'h0000_3000; mem_gnt = 1;
      #1 chk("first_grant", 128'(gnt), 128'(4'b0010));
      step();
      req = 4'b1000;
      #1 chk("second_grant", 128'(gnt), 128'(4'b1000));
      step();
      req = '0; mem_gnt = 0;
      for (int c = 0; c < 2; c++) begin drive_bank(1, 0); step(); end
      drive_bank(0, 0);

      // Round-robin with all requesters active, responses two cycles behind grants
      do_reset();
      req = '1; mem_gnt = 1;
      for (int i = 0; i < N; i++) addr[i] = AW'(32'h100 * (i + 1));
      for (int c = 0; c < 8; c++) begin
         drive_bank(c >= 2, 0);
         #1 chk("rr_order", 128'(gnt), 128'(1 << (c % N)));
         step();
      end
      req = '0;
      for (int c = 0; c < 2; c++) begin drive_bank(1, 0); step(); end
      drive_bank(0, 0);

      // Lock under stall: req0 rising must not steal the stalled req1 slot
      do_reset();
      addr[0] = 32'h0000_0A00; addr[1] = 32'h1111_1000;
      req = 4'b0010; mem_gnt = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) req = 4'b0011;
         #1 chk("lock_addr", 128'(mem_addr), 128'(32'h1111_1000));
         step();
      end
      mem_gnt = 1;
      #1 chk("lock_gnt1", 128'(gnt), 128'(4'b0010));
      step();
      req = 4'b0001;
      #1 chk("lock_gnt0_next", 128'(gnt), 128'(4'b0001));
      step();
      req = '0;
      for (int c = 0; c < 2; c++) begin drive_bank(1, 0); step(); end
      drive_bank(0, 0);

      // FIFO full, then a pop does not free the slot in the same cycle
      do_reset();
      req = '1; mem_gnt = 1;
      for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
      for (int c = 0; c < 4; c++) step();
      #1 chk("full_outstanding", 128'(outstanding), 128'(4));
      chk("full_mem_req", 128'(mem_req), 128'(0));
      step();
      drive_bank(1, 0);
      #1 chk("fullpop_no_gnt", 128'(gnt), 128'(0));
      chk("fullpop_mem_req", 128'(mem_req), 128'(0));
      step();
      drive_bank(0, 0);
      #1 chk("fullpop_next_gnt", 128'(gnt), 128'(4'b0001));
      step();
      #1 chk("fullpop_outstanding", 128'(outstanding), 128'(4));
      req = '0;
      for (int c = 0; c < 4; c++) begin drive_bank(1, 0); step(); end
      drive_bank(0, 0);

      // Simultaneous push/pop with an error response for requester 2
      do_reset();
      for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
      req = 4'b0100; mem_gnt = 1;
      step();
      req = 4'b0001; drive_bank(1, 1);
      #1 chk("pp_rvalid", 128'(rvalid), 128'(4'b0100));
      chk("pp_err", 128'(err), 128'(4'b0100));
      chk("pp_gnt", 128'(gnt), 128'(4'b0001));
      step();
      #1 chk("pp_outstanding", 128'(outstanding), 128'(1));
      req = '0; drive_bank(1, 0);
      step();
      drive_bank(0, 0);

      // Spurious response sets a sticky protocol error
      do_reset();
      drive_bank(1, 0);
      #1 chk("spur_no_rvalid", 128'(rvalid), 128'(0));
      step();
      drive_bank(0, 0);
      #1 chk("spur_proto_err", 128'(proto_err), 128'(1));
      for (int c = 0; c < 5; c++) step();
      chk("spur_sticky", 128'(proto_err), 128'(1));

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_req(1);
         mem_gnt = ($urandom_range(0, 9) < 7);
         drive_bank((bank_q.size() > 0) && 1'($urandom), ($urandom_range(0, 7) == 0));
         step();
      end
      for (int c = 0; c < 80 && (bank_q.size() > 0 || (|req)); c++) begin
         rand_req(0);
         mem_gnt = 1;
         drive_bank(bank_q.size() > 0, 0);
         step();
      end
      drive_bank(0, 0);
      #1 chk("drain_outstanding", 128'(outstanding), 128'(0));
      chk("drain_no_proto_err", 128'(proto_err), 128'(0));

      do_reset();
      chk("final_proto_err_cleared", 128'(proto_err), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
